vx_commit_packet_merge: RTL and testbench
=========================================

# vx_commit_packet_merge

Downstream neighbour of the dispatch stage, placed on the execute-to-commit path of each execute block. It accepts the lane-sliced packets (pid/sop/eop) an execute unit produces when `NUM_LANES < NUM_THREADS`. It reassembles them into one full-warp writeback record per instruction and hands that record to commit through a valid/ready handshake. When `NUM_LANES == NUM_THREADS` it degenerates to a one-entry registered pass-through.

## Interface
- `NUM_THREADS`, 16: warp width; must be a multiple of `NUM_LANES`.
- `NUM_LANES`, 4: lanes per input packet.
- `XLEN`, 32: data width per lane.
- `NW_WIDTH`, 4: warp-id width.
- `UUID_WIDTH`, 44: instruction uuid width.
- `NR_BITS`, 6: destination register index width.
- Derived: `NUM_PACKETS = NUM_THREADS/NUM_LANES`; `PID_WIDTH = max(1, clog2(NUM_PACKETS))`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low: 0 = reset.
- `in_valid`  in  1  packet valid.
- `in_ready`  out  1  packet accepted when `in_valid && in_ready`.
- `in_uuid`  in  `UUID_WIDTH`  instruction uuid.
- `in_wid`  in  `NW_WIDTH`  warp id.
- `in_rd`  in  `NR_BITS`  destination register.
- `in_wb`  in  1  writeback enable.
- `in_pid`  in  `PID_WIDTH`  packet index within the warp.
- `in_sop`  in  1  first packet of the instruction.
- `in_eop`  in  1  last packet of the instruction.
- `in_tmask`  in  `NUM_LANES`  active lanes in the packet.
- `in_data`  in  `NUM_LANES*XLEN`  lane results; lane j sits at bits `[j*XLEN +: XLEN]`.
- `out_valid`  out  1  merged record valid.
- `out_ready`  in  1  commit accepts the record.
- `out_uuid`, `out_wid`, `out_rd`, `out_wb`  out  same widths as the inputs  taken from the sop packet.
- `out_tmask`  out  `NUM_THREADS`  merged thread mask.
- `out_data`  out  `NUM_THREADS*XLEN`  merged results.
- `err`  out  1  sticky protocol-error flag.
- `instr_count`  out  32  number of merged records delivered.

## Operation
- State machine states are IDLE, COLLECT and FULL.
- **IDLE**
  - `in_ready = 1`.
  - An accepted packet with `sop=1` does the following:
    - Clears the accumulator.
    - Latches uuid, wid, rd and wb.
    - Writes its tmask and data into slot `in_pid`.
    - Moves to FULL if `eop=1`, otherwise to COLLECT.
  - An accepted packet with `sop=0` is dropped and sets `err`.
- **COLLECT**
  - `in_ready = 1`.
  - An accepted packet writes slot `in_pid`: thread `k = in_pid*NUM_LANES + j` gets `in_tmask[j]` and `in_data[j]`.
  - Header fields are not re-latched.
  - On `eop=1` the state moves to FULL.
  - An accepted `sop=1` in COLLECT sets `err`, discards the partial record, and restarts collection with that packet.
- **FULL**
  - `out_valid = 1`.
  - `in_ready = out_ready`, which allows the next packet in the same cycle as the output handshake.
  - On `out_valid && out_ready`:
    - `instr_count` increments; it wraps from 2^32-1 to 0.
    - The next state is determined by the packet accepted in that same cycle, exactly as if the state were IDLE; with no packet accepted, the next state is IDLE.
- **Slot handling**
  - pids within one instruction are strictly ascending but may skip values, because empty packets are never sent.
  - Slots that are never written stay at tmask 0 and data 0.
  - A pid that is not greater than the previous pid of the same instruction sets `err`; the packet is still written.
- **Degenerate case** (`NUM_PACKETS == 1`): `in_pid` is ignored, and every packet is treated as `sop=eop=1`.
- **err**: once set, stays 1 until reset.

## Timing
- During reset (`reset=0`):
  - State goes to IDLE.
  - `out_valid=0`, `in_ready=0`.
  - `out_tmask=0`, `out_data=0`, all header outputs 0.
  - `err=0`, `instr_count=0`.
- `in_ready` is 1 from the first cycle after reset is released.
- Latency: when an eop packet is accepted in cycle N, `out_valid=1` in cycle N+1, and the record includes that packet's lanes.
- All outputs are registered, and `out_*` stay stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally only on the state and `out_ready`, never on `in_valid`.
- Throughput: one input packet per cycle. A single-packet instruction stream sustains one record per cycle when `out_ready=1`.
- Reset asserted mid-collection drops the partial record; no output is produced for it.

## Test plan
- NUM_LANES=4, NUM_THREADS=16; send pids 0..3 with tmask 4'hF each and data 32'h100+k -> exactly one record, one cycle after the eop packet: tmask 16'hFFFF, data lane k = 32'h100+k, `instr_count=1`.
- Sparse instruction: pid 1 (sop, tmask 4'h3) then pid 3 (eop, tmask 4'h8) -> `out_tmask=16'h8030`; slots 0 and 2 data are 0; `err=0`.
- Backpressure: hold `out_ready=0` for 5 cycles with the next sop pending -> `in_ready=0` and the output stays stable. When `out_ready` rises, the record is delivered and the pending sop is accepted in the same cycle.
- Protocol error: sop pid 0, then sop pid 0 again before any eop -> `err=1` stays asserted; only the second instruction's record is emitted.
- Reset (`reset=0`) asserted after 2 of 4 packets, then released -> no output, `in_ready=1`; the next full instruction merges correctly with `instr_count=1`.
- Streaming: 20 back-to-back single-packet instructions (sop=eop=1) in the NUM_LANES=NUM_THREADS=4 configuration with `out_ready=1` -> 20 records on 20 consecutive cycles, `instr_count=20`.

Source files
------------

// File: rtl/vx_commit_packet_merge.sv
// Reassembles lane-sliced execute packets into one full-warp writeback record
// and presents it to commit over a valid/ready handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no instruction open; waiting for a sop packet
//   COLLECT | sop seen, accumulating packets until eop
//   FULL    | record complete and presented on out_*; held until out_ready
module vx_commit_packet_merge #(
  parameter int NUM_THREADS = 16,
  parameter int NUM_LANES   = 4,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 4,
  parameter int UUID_WIDTH  = 44,
  parameter int NR_BITS     = 6,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic                        in_wb,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [NR_BITS-1:0]          out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        err,
  output logic [31:0]                 instr_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_live;
  logic [PID_WIDTH-1:0]          r_last_pid;
  logic [UUID_WIDTH-1:0]         r_uuid;
  logic [NW_WIDTH-1:0]           r_wid;
  logic [NR_BITS-1:0]            r_rd;
  logic                          r_wb;
  logic [NUM_THREADS-1:0]        r_tmask;
  logic [NUM_THREADS*XLEN-1:0]   r_data;
  logic                          r_err;
  logic [31:0]                   r_count;

  logic                          w_sop;
  logic                          w_eop;
  logic [PID_WIDTH-1:0]          w_pid;
  logic                          w_accept;
  logic                          w_out_fire;
  logic                          w_start;
  logic                          w_write;
  logic                          w_set_err;

  // With a single packet per warp every packet is a whole instruction.
  assign w_sop = (NUM_PACKETS == 1) ? 1'b1 : in_sop;
  assign w_eop = (NUM_PACKETS == 1) ? 1'b1 : in_eop;
  assign w_pid = (NUM_PACKETS == 1) ? '0 : in_pid;

  // r_live keeps in_ready low while reset is held, without looking at in_valid.
  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = r_live && ((r_state != S_FULL) || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign out_uuid    = r_uuid;
  assign out_wid     = r_wid;
  assign out_rd      = r_rd;
  assign out_wb      = r_wb;
  assign out_tmask   = r_tmask;
  assign out_data    = r_data;
  assign err         = r_err;
  assign instr_count = r_count;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and accumulator control; a FULL that hands off behaves as IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_write     = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (w_sop) begin
            w_start   = 1'b1;
            w_set_err = 1'b1;
          end else if (w_pid <= r_last_pid) begin
            w_set_err = 1'b1;
          end
          if (w_eop) begin
            w_state_nxt = S_FULL;
          end
        end
      end
      default: begin
        if ((r_state == S_FULL) && !out_ready) begin
          w_state_nxt = S_FULL;
        end else begin
          w_state_nxt = S_IDLE;
          if (w_accept) begin
            if (w_sop) begin
              w_start     = 1'b1;
              w_write     = 1'b1;
              w_state_nxt = w_eop ? S_FULL : S_COLLECT;
            end else begin
              w_set_err = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // Header latch, slot writes, sticky error and delivered-record counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_live     <= 1'b0;
      r_last_pid <= '0;
      r_uuid     <= '0;
      r_wid      <= '0;
      r_rd       <= '0;
      r_wb       <= 1'b0;
      r_tmask    <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_out_fire) begin
        r_count <= r_count + 32'd1;
      end
      if (w_start) begin
        r_uuid <= in_uuid;
        r_wid  <= in_wid;
        r_rd   <= in_rd;
        r_wb   <= in_wb;
      end
      if (w_write) begin
        r_last_pid <= w_pid;
      end
      for (int p = 0; p < NUM_PACKETS; p++) begin
        if (w_write && (w_pid == PID_WIDTH'(p))) begin
          r_tmask[p*NUM_LANES +: NUM_LANES]      <= in_tmask;
          r_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= in_data;
        end else if (w_start) begin
          r_tmask[p*NUM_LANES +: NUM_LANES]      <= '0;
          r_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_commit_packet_merge.sv
// Bench for vx_commit_packet_merge: a 16-thread/4-lane instance and a
// 4-thread/4-lane pass-through instance, both checked every cycle against a
// transaction-level model of open instruction / pending record.
module tb_vx_commit_packet_merge;
  localparam int NT  = 16;
  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int NWW = 4;
  localparam int UW  = 44;
  localparam int NRB = 6;
  localparam int PW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic              a_in_valid, a_in_ready, a_in_wb, a_in_sop, a_in_eop;
  logic [UW-1:0]     a_in_uuid;
  logic [NWW-1:0]    a_in_wid;
  logic [NRB-1:0]    a_in_rd;
  logic [PW-1:0]     a_in_pid;
  logic [NL-1:0]     a_in_tmask;
  logic [NL*XL-1:0]  a_in_data;
  logic              a_out_valid, a_out_ready, a_out_wb, a_err;
  logic [UW-1:0]     a_out_uuid;
  logic [NWW-1:0]    a_out_wid;
  logic [NRB-1:0]    a_out_rd;
  logic [NT-1:0]     a_out_tmask;
  logic [NT*XL-1:0]  a_out_data;
  logic [31:0]       a_instr_count;

  logic              b_in_valid, b_in_ready, b_in_wb, b_in_sop, b_in_eop;
  logic [UW-1:0]     b_in_uuid;
  logic [NWW-1:0]    b_in_wid;
  logic [NRB-1:0]    b_in_rd;
  logic [0:0]        b_in_pid;
  logic [NL-1:0]     b_in_tmask;
  logic [NL*XL-1:0]  b_in_data;
  logic              b_out_valid, b_out_ready, b_out_wb, b_err;
  logic [UW-1:0]     b_out_uuid;
  logic [NWW-1:0]    b_out_wid;
  logic [NRB-1:0]    b_out_rd;
  logic [NL-1:0]     b_out_tmask;
  logic [NL*XL-1:0]  b_out_data;
  logic [31:0]       b_instr_count;

  vx_commit_packet_merge #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL),
    .NW_WIDTH(NWW), .UUID_WIDTH(UW), .NR_BITS(NRB)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_uuid(a_in_uuid),
    .in_wid(a_in_wid), .in_rd(a_in_rd), .in_wb(a_in_wb), .in_pid(a_in_pid),
    .in_sop(a_in_sop), .in_eop(a_in_eop), .in_tmask(a_in_tmask), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_uuid(a_out_uuid),
    .out_wid(a_out_wid), .out_rd(a_out_rd), .out_wb(a_out_wb),
    .out_tmask(a_out_tmask), .out_data(a_out_data),
    .err(a_err), .instr_count(a_instr_count));

  vx_commit_packet_merge #(.NUM_THREADS(NL), .NUM_LANES(NL), .XLEN(XL),
    .NW_WIDTH(NWW), .UUID_WIDTH(UW), .NR_BITS(NRB)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uuid(b_in_uuid),
    .in_wid(b_in_wid), .in_rd(b_in_rd), .in_wb(b_in_wb), .in_pid(b_in_pid),
    .in_sop(b_in_sop), .in_eop(b_in_eop), .in_tmask(b_in_tmask), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uuid(b_out_uuid),
    .out_wid(b_out_wid), .out_rd(b_out_rd), .out_wb(b_out_wb),
    .out_tmask(b_out_tmask), .out_data(b_out_data),
    .err(b_err), .instr_count(b_instr_count));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Model of instance A: an open partial record and a pending output record.
  bit               m_live = 0, m_full = 0, m_open = 0, m_err = 0;
  int               m_last_pid = 0;
  int unsigned      m_count = 0;
  logic [NT-1:0]    m_ptm, m_rtm;
  logic [NT*XL-1:0] m_pdat, m_rdat;
  logic [UW-1:0]    m_puuid, m_ruuid;
  logic [NWW-1:0]   m_pwid, m_rwid;
  logic [NRB-1:0]   m_prd, m_rrd;
  logic             m_pwb, m_rwb;

  // Model of instance B: every accepted packet is a record.
  bit               m2_live = 0, m2_full = 0;
  int unsigned      m2_count = 0;
  logic [NL-1:0]    m2_rtm;
  logic [NL*XL-1:0] m2_rdat;
  logic [UW-1:0]    m2_ruuid;
  logic [NWW-1:0]   m2_rwid;
  logic [NRB-1:0]   m2_rrd;
  logic             m2_rwb;

  task automatic step();
    bit a_rdy, b_rdy;
    int pid;
    @(negedge clk);
    a_rdy = m_live && (!m_full || a_out_ready);
    b_rdy = m2_live && (!m2_full || b_out_ready);
    chk("a_in_ready", a_in_ready, a_rdy);
    chk("a_out_valid", a_out_valid, m_full);
    chk("a_err", a_err, m_err);
    chk("a_count", a_instr_count, m_count);
    if (m_full) begin
      chk("a_tmask", a_out_tmask, m_rtm);
      chk("a_data", a_out_data, m_rdat);
      chk("a_hdr", {a_out_uuid, a_out_wid, a_out_rd, a_out_wb}, {m_ruuid, m_rwid, m_rrd, m_rwb});
    end
    chk("b_in_ready", b_in_ready, b_rdy);
    chk("b_out_valid", b_out_valid, m2_full);
    chk("b_err", b_err, 1'b0);
    chk("b_count", b_instr_count, m2_count);
    if (m2_full) begin
      chk("b_tmask", b_out_tmask, m2_rtm);
      chk("b_data", b_out_data, m2_rdat);
      chk("b_hdr", {b_out_uuid, b_out_wid, b_out_rd, b_out_wb}, {m2_ruuid, m2_rwid, m2_rrd, m2_rwb});
    end
    if (!reset) begin
      m_live = 0; m_full = 0; m_open = 0; m_err = 0; m_count = 0;
      m2_live = 0; m2_full = 0; m2_count = 0;
    end else begin
      if (m_full && a_out_ready) begin
        m_full = 0;
        m_count++;
      end
      if (a_in_valid && a_rdy) begin
        pid = int'(a_in_pid);
        if (a_in_sop) begin
          if (m_open) m_err = 1;
          m_open = 1;
          m_ptm = '0;
          m_pdat = '0;
          m_puuid = a_in_uuid; m_pwid = a_in_wid; m_prd = a_in_rd; m_pwb = a_in_wb;
          m_ptm[pid*NL +: NL] = a_in_tmask;
          m_pdat[pid*NL*XL +: NL*XL] = a_in_data;
          m_last_pid = pid;
        end else if (!m_open) begin
          m_err = 1;
        end else begin
          if (pid <= m_last_pid) m_err = 1;
          m_ptm[pid*NL +: NL] = a_in_tmask;
          m_pdat[pid*NL*XL +: NL*XL] = a_in_data;
          m_last_pid = pid;
        end
        if (m_open && a_in_eop) begin
          m_open = 0;
          m_full = 1;
          m_rtm = m_ptm; m_rdat = m_pdat;
          m_ruuid = m_puuid; m_rwid = m_pwid; m_rrd = m_prd; m_rwb = m_pwb;
        end
      end
      m_live = 1;
      if (m2_full && b_out_ready) begin
        m2_full = 0;
        m2_count++;
      end
      if (b_in_valid && b_rdy) begin
        m2_full = 1;
        m2_rtm = b_in_tmask; m2_rdat = b_in_data;
        m2_ruuid = b_in_uuid; m2_rwid = b_in_wid; m2_rrd = b_in_rd; m2_rwb = b_in_wb;
      end
      m2_live = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NL*XL-1:0] rnd_data();
    logic [NL*XL-1:0] d;
    for (int j = 0; j < NL; j++) d[j*XL +: XL] = $urandom();
    return d;
  endfunction

  function automatic logic [NL*XL-1:0] seq_data(input int pid);
    logic [NL*XL-1:0] d;
    for (int j = 0; j < NL; j++) d[j*XL +: XL] = 32'h100 + 32'(pid*NL + j);
    return d;
  endfunction

  task automatic drv_a(input bit v, input int pid, input bit sop, input bit eop,
                       input logic [NL-1:0] tm, input logic [NL*XL-1:0] d);
    a_in_valid = v; a_in_pid = PW'(pid); a_in_sop = sop; a_in_eop = eop;
    a_in_tmask = tm; a_in_data = d;
    a_in_uuid = UW'({$urandom(), $urandom()});
    a_in_wid = NWW'($urandom()); a_in_rd = NRB'($urandom()); a_in_wb = 1'($urandom());
  endtask

  task automatic drv_b(input bit v);
    b_in_valid = v; b_in_pid = 1'($urandom()); b_in_sop = 1'($urandom());
    b_in_eop = 1'($urandom()); b_in_tmask = NL'($urandom()); b_in_data = rnd_data();
    b_in_uuid = UW'({$urandom(), $urandom()});
    b_in_wid = NWW'($urandom()); b_in_rd = NRB'($urandom()); b_in_wb = 1'($urandom());
  endtask

  task automatic send_full_seq();
    for (int p = 0; p < 4; p++) begin
      drv_a(1, p, p == 0, p == 3, 4'hF, seq_data(p));
      step();
    end
    a_in_valid = 0;
  endtask

  initial begin
    logic [NT*XL-1:0] exp_seq;
    for (int k = 0; k < NT; k++) exp_seq[k*XL +: XL] = 32'h100 + 32'(k);

    reset = 0;
    drv_a(0, 0, 0, 0, '0, '0);
    drv_b(0);
    a_out_ready = 1;
    b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_tmask", a_out_tmask, '0);
    chk("rst_data", a_out_data, '0);
    chk("rst_hdr", {a_out_uuid, a_out_wid, a_out_rd, a_out_wb}, '0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_count", a_instr_count, '0);
    reset = 1;
    step();
    step();

    // Four dense packets merge into one record one cycle after eop.
    send_full_seq();
    chk("full_valid", a_out_valid, 1'b1);
    chk("full_tmask", a_out_tmask, 16'hFFFF);
    chk("full_data", a_out_data, exp_seq);
    step();
    step();
    chk("full_count", a_instr_count, 32'd1);

    // Sparse pids leave unwritten slots at zero.
    drv_a(1, 1, 1, 0, 4'h3, rnd_data());
    step();
    drv_a(1, 3, 0, 1, 4'h8, rnd_data());
    step();
    a_in_valid = 0;
    chk("sparse_tmask", a_out_tmask, 16'h8030);
    chk("sparse_slot0", a_out_data[127:0], '0);
    chk("sparse_slot2", a_out_data[383:256], '0);
    chk("sparse_err", a_err, 1'b0);
    step();
    step();

    // Backpressure with the next sop waiting.
    drv_a(1, 0, 1, 1, 4'hF, rnd_data());
    step();
    a_out_ready = 0;
    drv_a(1, 2, 1, 1, 4'h5, rnd_data());
    repeat (5) step();
    chk("bp_in_ready", a_in_ready, 1'b0);
    a_out_ready = 1;
    step();
    a_in_valid = 0;
    chk("bp_next_tmask", a_out_tmask, 16'h0500);
    step();
    step();

    // Reset in the middle of a collection drops the partial record.
    drv_a(1, 0, 1, 0, 4'hF, rnd_data());
    step();
    drv_a(1, 1, 0, 0, 4'hF, rnd_data());
    step();
    a_in_valid = 0;
    reset = 0;
    step();
    reset = 1;
    step();
    step();
    chk("mid_rst_ready", a_in_ready, 1'b1);
    send_full_seq();
    step();
    step();
    chk("mid_rst_count", a_instr_count, 32'd1);

    // Streaming through the single-packet instance.
    b_out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drv_b(1);
      step();
    end
    b_in_valid = 0;
    step();
    step();
    chk("stream_count", b_instr_count, 32'd20);

    // Repeated sop before eop is an error; only the restarted record appears.
    drv_a(1, 0, 1, 0, 4'h1, rnd_data());
    step();
    drv_a(1, 0, 1, 1, 4'h2, rnd_data());
    step();
    a_in_valid = 0;
    chk("proto_err", a_err, 1'b1);
    chk("proto_tmask", a_out_tmask, 16'h0002);
    step();
    step();
    chk("proto_err_sticky", a_err, 1'b1);

    // Random traffic on both instances.
    for (int i = 0; i < 800; i++) begin
      drv_a(($urandom() % 4) != 0, int'($urandom() % 4), ($urandom() % 3) == 0,
            ($urandom() % 3) == 0, NL'($urandom()), rnd_data());
      a_out_ready = ($urandom() % 4) != 0;
      drv_b(($urandom() % 3) != 0);
      b_out_ready = ($urandom() % 3) != 0;
      step();
    end
    a_in_valid = 0;
    b_in_valid = 0;
    a_out_ready = 1;
    b_out_ready = 1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
